dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported data memory between the CPU load/store stage (port 0) and a DMA/debug loader (port 1).
- Picks one winner per cycle and drives the memory's address, write data, write enable and read enable.
- Captures the memory's combinational read data into a per-port registered response.
- CPU has priority; a starvation counter guarantees DMA forward progress. Misaligned accesses are rejected with an error response.

---
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU
// load/store stage (port 0) and a DMA/debug loader (port 1).
// CPU has priority; a starvation counter forces a DMA win after
// STARVE_LIMIT consecutive lost cycles. Misaligned accesses get an error
// response and never touch memory. Response latency is one cycle.

// Per-port registered response: rvalid pulse, err flag and read data.
module dmem_arb_port #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              win_i,      // this port won arbitration this cycle
    input  logic              ok_i,       // winner's access is aligned
    input  logic              we_i,       // this port's request is a write
    input  logic [DATA_W-1:0] mem_out_i,  // combinational memory read data
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              err_o
);

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q;
    logic              err_q;

    // Writes and rejected accesses return zero data; rdata holds when not won.
    always_comb begin
        rdata_d = rdata_q;
        if (win_i) rdata_d = (ok_i && !we_i) ? mem_out_i : '0;
    end

    // Response registers: one-cycle rvalid pulse per accepted request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= win_i;
            err_q    <= win_i & ~ok_i;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

endmodule

// Top-level arbiter.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,   // 1..15
    parameter int CHECK_ALIGN  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    // port 0: CPU
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_err,
    // port 1: DMA / debug loader
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_err,
    // memory side
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int         NUM_PORTS = 2;
    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

    // Ports gathered into packed arrays so the datapath is indexed by winner.
    logic [NUM_PORTS-1:0]             req, we, gnt;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;
    logic [NUM_PORTS-1:0]             rvalid, err;

    assign req   = {dma_req,   cpu_req};
    assign we    = {dma_we,    cpu_we};
    assign addr  = {dma_addr,  cpu_addr};
    assign wdata = {dma_wdata, cpu_wdata};

    logic [3:0]        starve_q, starve_d;
    logic              sel;        // winning port index
    logic              any_win;
    logic              aligned;
    logic              act;        // winner is allowed to touch memory
    logic [ADDR_W-1:0] win_addr;

    // Arbitration: CPU first unless DMA has lost STARVE_LIMIT cycles in a row.
    // Grants are held low during reset so nothing reaches memory.
    always_comb begin
        gnt = '0;
        if (reset_n) begin
            if (req[0] && req[1]) gnt = (starve_q == LIMIT) ? 2'b10 : 2'b01;
            else                  gnt = req;
        end
    end

    assign sel      = gnt[1];
    assign any_win  = |gnt;
    assign win_addr = addr[sel];
    assign aligned  = (CHECK_ALIGN == 0) || (win_addr[1:0] == 2'b00);
    assign act      = any_win && aligned;

    // Memory drive: idle or rejected accesses present all-zero signals.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        if (act) begin
            mem_address      = win_addr;
            mem_write_data   = wdata[sel];
            mem_write_enable = we[sel];
            mem_read_enable  = ~we[sel];
        end
    end

    // Starvation count: counts DMA's consecutive losses, saturating at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!dma_req || gnt[1]) starve_d = '0;
        else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
    end

    // Starvation counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end

    // One response slice per port; all share the memory read data.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        dmem_arb_port #(.DATA_W(DATA_W)) u_port (
            .clock     (clock),
            .reset_n   (reset_n),
            .win_i     (gnt[g]),
            .ok_i      (aligned),
            .we_i      (we[g]),
            .mem_out_i (mem_out),
            .rdata_o   (rdata[g]),
            .rvalid_o  (rvalid[g]),
            .err_o     (err[g])
        );
    end

    assign cpu_gnt    = gnt[0];
    assign dma_gnt    = gnt[1];
    assign cpu_rdata  = rdata[0];
    assign dma_rdata  = rdata[1];
    assign cpu_rvalid = rvalid[0];
    assign dma_rvalid = rvalid[1];
    assign cpu_err    = err[0];
    assign dma_err    = err[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_address, mem_write_data, mem_out;
    logic        mem_write_enable, mem_read_enable;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CHECK_ALIGN(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_err(dma_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_out(mem_out)
    );

    // 64-word memory: combinational read, write on rising edge.
    logic [31:0] mem [0:63];
    assign mem_out = mem[mem_address[7:2]];
    always @(posedge clock) if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;

    task automatic test_reset_state();
        #1;
        total++;
        if ({cpu_gnt, dma_gnt, mem_write_enable, mem_read_enable, cpu_rvalid, dma_rvalid, cpu_err, dma_err} !== 8'h00)
            $display("FAIL reset_flags got %b exp 00000000",
                     {cpu_gnt, dma_gnt, mem_write_enable, mem_read_enable, cpu_rvalid, dma_rvalid, cpu_err, dma_err});
        else pass_cnt++;
        total++;
        if ({cpu_rdata, dma_rdata} !== 64'h0)
            $display("FAIL reset_rdata got %h/%h exp 0/0", cpu_rdata, dma_rdata);
        else pass_cnt++;
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic test_cpu_read();
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
        #1;
        total++;
        if ({cpu_gnt, dma_gnt, mem_read_enable, mem_write_enable} !== 4'b1010 || mem_address !== 32'h8)
            $display("FAIL rd_grant got gnt=%b%b re=%b we=%b a=%h exp 1010 a=8",
                     cpu_gnt, dma_gnt, mem_read_enable, mem_write_enable, mem_address);
        else pass_cnt++;
        @(posedge clock); #1; cpu_req = 0;
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'hDEADBEEF || dma_rvalid !== 1'b0)
            $display("FAIL rd_resp got v=%b e=%b d=%h dv=%b exp 1 0 deadbeef 0",
                     cpu_rvalid, cpu_err, cpu_rdata, dma_rvalid);
        else pass_cnt++;
        @(posedge clock); #1;
        total++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF)
            $display("FAIL rd_pulse got v=%b d=%h exp 0 deadbeef", cpu_rvalid, cpu_rdata);
        else pass_cnt++;
    endtask

    task automatic test_write_then_read();
        @(negedge clock);
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
        #1;
        total++;
        if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_write_enable !== 1'b1 || mem_write_data !== 32'h12345678)
            $display("FAIL wr_grant got g=%b we=%b wd=%h exp 1 1 12345678", dma_gnt, mem_write_enable, mem_write_data);
        else pass_cnt++;
        @(posedge clock); #1; dma_req = 0;
        total++;
        if (dma_rvalid !== 1'b1 || dma_err !== 1'b0 || dma_rdata !== 32'h0 || mem[8] !== 32'h12345678)
            $display("FAIL wr_resp got v=%b e=%b d=%h m=%h exp 1 0 0 12345678", dma_rvalid, dma_err, dma_rdata, mem[8]);
        else pass_cnt++;
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        @(posedge clock); #1; cpu_req = 0;
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678)
            $display("FAIL wr_then_rd got v=%b d=%h exp 1 12345678", cpu_rvalid, cpu_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hAAAA5555;
        @(negedge clock); reset_n = 0;
        #1;
        total++;
        if ({cpu_gnt, dma_gnt, mem_write_enable, mem_read_enable, cpu_rvalid, cpu_err} !== 6'h00 || cpu_rdata !== 32'h0)
            $display("FAIL rst_mid_out got g=%b we=%b v=%b d=%h exp 0 0 0 0", cpu_gnt, mem_write_enable, cpu_rvalid, cpu_rdata);
        else pass_cnt++;
        @(posedge clock); #1;
        total++;
        if (mem[4] !== 32'h0 || cpu_rvalid !== 1'b0)
            $display("FAIL rst_mid_nowrite got m=%h v=%b exp 0 0", mem[4], cpu_rvalid);
        else pass_cnt++;
        cpu_req = 0;
        @(negedge clock); reset_n = 1;
        @(negedge clock);
        cpu_req = 1;
        #1;
        total++;
        if (cpu_gnt !== 1'b1 || mem_write_enable !== 1'b1)
            $display("FAIL rst_reissue_gnt got g=%b we=%b exp 1 1", cpu_gnt, mem_write_enable);
        else pass_cnt++;
        @(posedge clock); #1; cpu_req = 0;
        total++;
        if (mem[4] !== 32'hAAAA5555 || cpu_rvalid !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0)
            $display("FAIL rst_reissue_resp got m=%h v=%b e=%b d=%h exp aaaa5555 1 0 0", mem[4], cpu_rvalid, cpu_err, cpu_rdata);
        else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic exp_dma;
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h8;
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            exp_dma = (i % 5 == 4);
            #1;
            total++;
            if (cpu_gnt !== ~exp_dma || dma_gnt !== exp_dma)
                $display("FAIL starve_gnt[%0d] got c=%b d=%b exp c=%b d=%b", i, cpu_gnt, dma_gnt, ~exp_dma, exp_dma);
            else pass_cnt++;
            @(posedge clock); #1;
            total++;
            if (cpu_rvalid !== ~exp_dma || dma_rvalid !== exp_dma ||
                (exp_dma && dma_rdata !== 32'h12345678) || (!exp_dma && cpu_rdata !== 32'hDEADBEEF))
                $display("FAIL starve_resp[%0d] got cv=%b dv=%b cd=%h dd=%h", i, cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata);
            else pass_cnt++;
            @(negedge clock);
        end
        cpu_req = 0; dma_req = 0;
    endtask

    task automatic test_misaligned();
        @(negedge clock);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h22; cpu_wdata = 32'hFFFFFFFF;
        #1;
        total++;
        if (cpu_gnt !== 1'b1 || mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0)
            $display("FAIL mis_gnt got g=%b we=%b re=%b exp 1 0 0", cpu_gnt, mem_write_enable, mem_read_enable);
        else pass_cnt++;
        @(posedge clock); #1; cpu_req = 0;
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0)
            $display("FAIL mis_resp got v=%b e=%b d=%h exp 1 1 0", cpu_rvalid, cpu_err, cpu_rdata);
        else pass_cnt++;
        @(negedge clock);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        @(posedge clock); #1; cpu_req = 0;
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h12345678)
            $display("FAIL mis_unchanged got v=%b e=%b d=%h exp 1 0 12345678", cpu_rvalid, cpu_err, cpu_rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // CPU write and DMA read of the same address collide; CPU goes first.
        @(negedge clock);
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
        dma_req = 1; dma_we = 0; dma_addr = 32'h30;
        #1;
        total++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0)
            $display("FAIL b2b_collide got c=%b d=%b exp 1 0", cpu_gnt, dma_gnt);
        else pass_cnt++;
        @(posedge clock); #1;
        @(negedge clock);
        cpu_we = 0;   // new read issued in the same cycle as the write's rvalid
        @(posedge clock); #1; cpu_req = 0;
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hCAFEF00D || dma_rvalid !== 1'b0)
            $display("FAIL b2b_read got v=%b d=%h dv=%b exp 1 cafef00d 0", cpu_rvalid, cpu_rdata, dma_rvalid);
        else pass_cnt++;
        @(posedge clock); #1; dma_req = 0;
        total++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hCAFEF00D)
            $display("FAIL b2b_loser_sees got v=%b d=%h exp 1 cafef00d", dma_rvalid, dma_rdata);
        else pass_cnt++;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            total++;
            if ({cpu_gnt, dma_gnt, mem_write_enable, mem_read_enable, cpu_rvalid, dma_rvalid} !== 6'h00 ||
                cpu_rdata !== 32'hCAFEF00D || dma_rdata !== 32'hCAFEF00D)
                $display("FAIL idle[%0d] got flags=%b cd=%h dd=%h exp 000000 cafef00d cafef00d", i,
                         {cpu_gnt, dma_gnt, mem_write_enable, mem_read_enable, cpu_rvalid, dma_rvalid}, cpu_rdata, dma_rdata);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset_n = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[2] = 32'hDEADBEEF;
        test_reset_state();
        test_cpu_read();
        test_write_then_read();
        test_reset_mid();
        test_starvation();
        test_misaligned();
        test_back_to_back();
        test_idle();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
